// File: rtl/arbitro_pkg.sv
// Shared types for the IF/MEM memory arbiter: FSM states, owner tags, memoriaBloco control encoding.
package arbitro_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ISSUE = 2'd1,
        RESP  = 2'd2
    } estado_t;

    typedef enum logic {
        DONO_IF  = 1'b0,
        DONO_MEM = 1'b1
    } dono_t;

    localparam logic CTRL_WRITE = 1'b0;
    localparam logic CTRL_READ  = 1'b1;

    // Everything about the winning request that must survive until RESP.
    typedef struct packed {
        dono_t       dono;
        logic        we;
        logic        fora;
        logic [31:0] addr;
        logic [31:0] wdata;
    } pedido_t;

    function automatic logic fora_de_faixa(input logic [31:0] addr, input int unsigned depth);
        return addr >= depth;
    endfunction

endpackage

// File: rtl/arbitro_memoria_contador_justica.sv
// Saturating count of consecutive MEM wins taken while IF was waiting; only built with ARB_FAIRNESS_EN.
// force_if is a registered view of count==LIMIT, so it takes effect at the next arbitration edge.
module contador_justica #(
    parameter int unsigned LIMIT = 4
) (
    input  logic clock,
    input  logic reset,
    input  logic if_req,
    input  logic mem_win,
    input  logic if_win,
    output logic force_if
);

    localparam int unsigned W = $clog2(LIMIT + 1);

    logic [W-1:0] count_q, count_d;

    always_comb begin
        count_d = count_q;
        if (!if_req || if_win) begin
            count_d = '0;
        end else if (mem_win && (count_q != W'(LIMIT))) begin
            count_d = count_q + 1'b1;
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end

    assign force_if = (count_q == W'(LIMIT));

endmodule

// File: rtl/arbitro_memoria.sv
// Shared single-port memory arbiter, IF fetch vs MEM load/store (MEM priority; ARB_FAIRNESS_EN adds IF anti-starvation).
// Valid 2 cycles after the arbitration edge, one access per 2 cycles; a loser is held off by withholding its gnt.
module arbitro_memoria
    import arbitro_pkg::*;
#(
    parameter int unsigned MEM_DEPTH    = 1501,
    parameter int unsigned STARVE_LIMIT = 4
) (
    input  logic        clock,
    input  logic        reset,
    input  logic        if_req,
    input  logic [31:0] if_addr,
    output logic        if_gnt,
    output logic        if_valid,
    output logic [31:0] if_rdata,
    input  logic        mem_req,
    input  logic        mem_we,
    input  logic [31:0] mem_addr,
    input  logic [31:0] mem_wdata,
    output logic        mem_gnt,
    output logic        mem_valid,
    output logic [31:0] mem_rdata,
    output logic        m_en,
    output logic        m_controle,
    output logic [31:0] m_addr,
    output logic [31:0] m_wdata,
    input  logic [31:0] m_rdata,
    output logic        err
);

    estado_t     state_q, state_d;
    pedido_t     lat_q, lat_d;
    logic [31:0] if_rdata_q, if_rdata_d;
    logic [31:0] mem_rdata_q, mem_rdata_d;
    logic        arb_ok, arb_evt, mem_wins, force_if;
    logic        issue, resp;
    logic [31:0] resp_data;

`ifdef ARB_FAIRNESS_EN
    contador_justica #(
        .LIMIT   (STARVE_LIMIT)
    ) u_contador_justica (
        .clock   (clock),
        .reset   (reset),
        .if_req  (if_req),
        .mem_win (arb_evt && mem_wins),
        .if_win  (arb_evt && !mem_wins),
        .force_if(force_if)
    );
`else
    logic unused_starve_limit;
    assign unused_starve_limit = (STARVE_LIMIT != 0);
    assign force_if            = 1'b0;
`endif

    always_comb begin
        arb_ok   = (state_q == IDLE) || (state_q == RESP);
        arb_evt  = arb_ok && (if_req || mem_req);
        mem_wins = mem_req && !(if_req && force_if);
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    state_d = arb_evt ? ISSUE : IDLE;
            ISSUE:   state_d = RESP;
            RESP:    state_d = arb_evt ? ISSUE : IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        lat_d = lat_q;
        if (arb_evt) begin
            if (mem_wins) begin
                lat_d.dono  = DONO_MEM;
                lat_d.we    = mem_we;
                lat_d.addr  = mem_addr;
                lat_d.wdata = mem_wdata;
            end else begin
                lat_d.dono  = DONO_IF;
                lat_d.we    = 1'b0;
                lat_d.addr  = if_addr;
                lat_d.wdata = '0;
            end
            // Range is judged once at latch time so ISSUE and RESP agree on it.
            lat_d.fora = fora_de_faixa(lat_d.addr, MEM_DEPTH);
        end
    end

    always_comb begin
        // Reset gates every strobe in its own cycle: no write lands and no valid escapes.
        issue      = (state_q == ISSUE) && !reset;
        resp       = (state_q == RESP) && !reset;
        resp_data  = lat_q.fora ? '0 : m_rdata;

        m_en       = issue && !lat_q.fora;
        m_controle = (issue && lat_q.we) ? CTRL_WRITE : CTRL_READ;
        m_addr     = lat_q.addr;
        m_wdata    = lat_q.wdata;

        if_gnt     = issue && (lat_q.dono == DONO_IF);
        mem_gnt    = issue && (lat_q.dono == DONO_MEM);
        if_valid   = resp && (lat_q.dono == DONO_IF);
        mem_valid  = resp && (lat_q.dono == DONO_MEM);
        err        = resp && lat_q.fora;

        if_rdata   = if_valid ? resp_data : if_rdata_q;
        mem_rdata  = (mem_valid && !lat_q.we) ? resp_data : mem_rdata_q;
    end

    always_comb begin
        if_rdata_d  = if_rdata;
        mem_rdata_d = mem_rdata;
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            lat_q       <= '0;
            if_rdata_q  <= '0;
            mem_rdata_q <= '0;
        end else begin
            lat_q       <= lat_d;
            if_rdata_q  <= if_rdata_d;
            mem_rdata_q <= mem_rdata_d;
        end
    end

endmodule

// File: tb/tb_arbitro_memoria.sv
// Bench for arbitro_memoria with a memoriaBloco stand-in preloaded Bloco[i]=i; fairness checks under ARB_FAIRNESS_EN.
module tb_arbitro_memoria;

    localparam int DEPTH = 1501;
    localparam int LIMIT = 4;
`ifdef ARB_FAIRNESS_EN
    localparam bit FAIR = 1'b1;
`else
    localparam bit FAIR = 1'b0;
`endif

    logic        clock = 1'b0;
    logic        reset = 1'b1;
    logic        if_req = 1'b0, mem_req = 1'b0, mem_we = 1'b0;
    logic [31:0] if_addr = '0, mem_addr = '0, mem_wdata = '0;
    logic        if_gnt, if_valid, mem_gnt, mem_valid, m_en, m_controle, err;
    logic [31:0] if_rdata, mem_rdata, m_addr, m_wdata;
    logic [31:0] m_rdata = '0;
    logic        preload = 1'b1;
    logic [31:0] bloco   [0:DEPTH-1];
    logic [31:0] ref_mem [0:DEPTH-1];
    int          m_en_cnt = 0;
    int          checks = 0, errors = 0;

    arbitro_memoria dut (
        .clock(clock), .reset(reset),
        .if_req(if_req), .if_addr(if_addr), .if_gnt(if_gnt), .if_valid(if_valid), .if_rdata(if_rdata),
        .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
        .mem_gnt(mem_gnt), .mem_valid(mem_valid), .mem_rdata(mem_rdata),
        .m_en(m_en), .m_controle(m_controle), .m_addr(m_addr), .m_wdata(m_wdata),
        .m_rdata(m_rdata), .err(err)
    );

    always #5 clock = ~clock;

    always @(posedge clock) begin
        if (preload) begin
            for (int i = 0; i < DEPTH; i++) bloco[i] <= i;
        end else if (m_en === 1'b1 && m_addr < DEPTH) begin
            if (m_controle == 1'b0) bloco[m_addr[10:0]] <= m_wdata;
            else                    m_rdata <= bloco[m_addr[10:0]];
        end
    end

    always @(posedge clock) if (m_en === 1'b1) m_en_cnt <= m_en_cnt + 1;

    task automatic tick;
        @(posedge clock);
        #1;
    endtask

    function automatic logic [31:0] pick_addr;
        int r;
        r = $urandom_range(0, 9);
        case (r)
            0:       return 32'd1500;
            1:       return 32'd1501;
            2:       return 32'h8000_0000 | 32'($urandom_range(0, 1000));
            default: return 32'd100 + 32'($urandom_range(0, 31));
        endcase
    endfunction

    task automatic test_reset;
        for (int i = 0; i < DEPTH; i++) ref_mem[i] = i;
        reset = 1'b1; preload = 1'b1;
        tick; tick;
        reset = 1'b0; preload = 1'b0;
        tick;
        checks++;
        if ({if_gnt, if_valid, mem_gnt, mem_valid, m_en, err, m_controle} !== 7'b0000001) begin
            errors++;
            $display("FAIL reset_ctrl: got %b expected 0000001",
                     {if_gnt, if_valid, mem_gnt, mem_valid, m_en, err, m_controle});
        end
        checks++;
        if (m_addr !== 0 || m_wdata !== 0 || if_rdata !== 0 || mem_rdata !== 0) begin
            errors++;
            $display("FAIL reset_data: got addr=%0h wdata=%0h if_rdata=%0h mem_rdata=%0h expected all 0",
                     m_addr, m_wdata, if_rdata, mem_rdata);
        end
    endtask

    task automatic test_if_read;
        if_req = 1'b1; if_addr = 32'd10;
        tick;
        checks++;
        if (if_gnt !== 1'b1 || mem_gnt !== 1'b0 || if_valid !== 1'b0 || m_en !== 1'b1 || m_controle !== 1'b1) begin
            errors++;
            $display("FAIL if_gnt_n1: got gnt=%b mgnt=%b valid=%b m_en=%b ctrl=%b expected 1 0 0 1 1",
                     if_gnt, mem_gnt, if_valid, m_en, m_controle);
        end
        if_req = 1'b0; if_addr = '0;
        tick;
        checks++;
        if (if_valid !== 1'b1 || if_rdata !== 32'd10 || err !== 1'b0 || if_gnt !== 1'b0) begin
            errors++;
            $display("FAIL if_valid_n2: got valid=%b rdata=%0d err=%b expected valid=1 rdata=10 err=0",
                     if_valid, if_rdata, err);
        end
        tick;
        checks++;
        if (if_valid !== 1'b0 || if_rdata !== 32'd10) begin
            errors++;
            $display("FAIL if_valid_pulse: got valid=%b rdata=%0d expected valid=0 rdata=10", if_valid, if_rdata);
        end
    endtask

    task automatic test_store_load;
        mem_req = 1'b1; mem_we = 1'b1; mem_addr = 32'd20; mem_wdata = 32'hDEAD;
        tick;
        checks++;
        if (mem_gnt !== 1'b1 || m_en !== 1'b1 || m_controle !== 1'b0 || m_addr !== 32'd20 || m_wdata !== 32'hDEAD) begin
            errors++;
            $display("FAIL store_issue: got gnt=%b m_en=%b ctrl=%b addr=%0d wdata=%0h expected 1 1 0 20 dead",
                     mem_gnt, m_en, m_controle, m_addr, m_wdata);
        end
        mem_we = 1'b0; mem_wdata = '0;
        tick;
        checks++;
        if (mem_valid !== 1'b1 || mem_gnt !== 1'b0 || err !== 1'b0) begin
            errors++;
            $display("FAIL store_valid: got valid=%b gnt=%b err=%b expected 1 0 0", mem_valid, mem_gnt, err);
        end
        tick;
        checks++;
        if (mem_gnt !== 1'b1 || m_controle !== 1'b1 || m_en !== 1'b1) begin
            errors++;
            $display("FAIL load_b2b_gnt: got gnt=%b ctrl=%b m_en=%b expected 1 1 1", mem_gnt, m_controle, m_en);
        end
        mem_req = 1'b0; mem_addr = '0;
        tick;
        checks++;
        if (mem_valid !== 1'b1 || mem_rdata !== 32'hDEAD) begin
            errors++;
            $display("FAIL load_data: got valid=%b rdata=%0h expected valid=1 rdata=dead", mem_valid, mem_rdata);
        end
        ref_mem[20] = 32'hDEAD;
        tick;
    endtask

    task automatic test_both;
        if_req = 1'b1; if_addr = 32'd40;
        mem_req = 1'b1; mem_we = 1'b0; mem_addr = 32'd30;
        tick;
        checks++;
        if (mem_gnt !== 1'b1 || if_gnt !== 1'b0) begin
            errors++;
            $display("FAIL both_mem_first: got mgnt=%b igнt=%b expected 1 0", mem_gnt, if_gnt);
        end
        mem_req = 1'b0; mem_addr = '0;
        tick;
        checks++;
        if (mem_valid !== 1'b1 || mem_rdata !== 32'd30 || if_gnt !== 1'b0) begin
            errors++;
            $display("FAIL both_mem_valid: got valid=%b rdata=%0d ignt=%b expected 1 30 0", mem_valid, mem_rdata, if_gnt);
        end
        tick;
        checks++;
        if (if_gnt !== 1'b1 || mem_valid !== 1'b0) begin
            errors++;
            $display("FAIL both_if_gnt: got ignt=%b mvalid=%b expected 1 0", if_gnt, mem_valid);
        end
        if_req = 1'b0; if_addr = '0;
        tick;
        checks++;
        if (if_valid !== 1'b1 || if_rdata !== 32'd40 || mem_valid !== 1'b0) begin
            errors++;
            $display("FAIL both_if_valid: got valid=%b rdata=%0d mvalid=%b expected 1 40 0", if_valid, if_rdata, mem_valid);
        end
        tick;
    endtask

    task automatic test_out_of_range;
        int n0;
        n0 = m_en_cnt;
        mem_req = 1'b1; mem_we = 1'b1; mem_addr = 32'd2000; mem_wdata = 32'hCAFE;
        tick;
        checks++;
        if (mem_gnt !== 1'b1 || m_en !== 1'b0) begin
            errors++;
            $display("FAIL oor_store_issue: got gnt=%b m_en=%b expected 1 0", mem_gnt, m_en);
        end
        mem_req = 1'b0; mem_we = 1'b0;
        tick;
        checks++;
        if (mem_valid !== 1'b1 || err !== 1'b1) begin
            errors++;
            $display("FAIL oor_store_err: got valid=%b err=%b expected 1 1", mem_valid, err);
        end
        tick;
        checks++;
        if (err !== 1'b0) begin
            errors++;
            $display("FAIL oor_err_pulse: got err=%b expected 0", err);
        end
        mem_req = 1'b1; mem_addr = 32'd2000;
        tick;
        mem_req = 1'b0;
        tick;
        checks++;
        if (mem_valid !== 1'b1 || err !== 1'b1 || mem_rdata !== 32'd0) begin
            errors++;
            $display("FAIL oor_load: got valid=%b err=%b rdata=%0h expected 1 1 0", mem_valid, err, mem_rdata);
        end
        tick;
        checks++;
        if (m_en_cnt !== n0) begin
            errors++;
            $display("FAIL oor_m_en_never: got %0d strobes expected 0", m_en_cnt - n0);
        end
    endtask

    task automatic test_reset_mid;
        int n0;
        n0 = m_en_cnt;
        mem_req = 1'b1; mem_we = 1'b1; mem_addr = 32'd5; mem_wdata = 32'hBEEF;
        tick;
        reset = 1'b1; mem_req = 1'b0; mem_we = 1'b0;
        #1;
        checks++;
        if (m_en !== 1'b0) begin
            errors++;
            $display("FAIL rst_mid_m_en: got %b expected 0", m_en);
        end
        tick;
        reset = 1'b0;
        checks++;
        if ({if_gnt, if_valid, mem_gnt, mem_valid, m_en, err, m_controle} !== 7'b0000001 ||
            m_addr !== 0 || m_wdata !== 0 || if_rdata !== 0 || mem_rdata !== 0) begin
            errors++;
            $display("FAIL rst_mid_outputs: got ctrl=%b addr=%0h wdata=%0h if_rdata=%0h mem_rdata=%0h expected 0000001 0 0 0 0",
                     {if_gnt, if_valid, mem_gnt, mem_valid, m_en, err, m_controle}, m_addr, m_wdata, if_rdata, mem_rdata);
        end
        tick;
        checks++;
        if (mem_valid !== 1'b0 || mem_gnt !== 1'b0) begin
            errors++;
            $display("FAIL rst_mid_no_valid: got valid=%b gnt=%b expected 0 0", mem_valid, mem_gnt);
        end
        tick;
        checks++;
        if (bloco[5] !== 32'd5 || m_en_cnt !== n0) begin
            errors++;
            $display("FAIL rst_mid_bloco5: got %0h with %0d strobes expected 5 with 0", bloco[5], m_en_cnt - n0);
        end
    endtask

    task automatic test_priority;
        int mem_grants = 0, if_grants = 0;
        int run[2] = '{-1, -1};
        if_req = 1'b1; if_addr = 32'd7;
        mem_req = 1'b1; mem_we = 1'b0; mem_addr = 32'd8;
        for (int cyc = 0; cyc < 60 && if_grants < 2; cyc++) begin
            tick;
            if (mem_gnt === 1'b1) mem_grants++;
            if (if_gnt === 1'b1) begin
                run[if_grants] = mem_grants;
                mem_grants = 0;
                if_grants++;
            end
        end
        checks++;
        if (FAIR) begin
            if (if_grants != 2 || run[0] != LIMIT || run[1] != LIMIT) begin
                errors++;
                $display("FAIL fair_starve: got if_grants=%0d runs=%0d,%0d expected 2 runs of %0d",
                         if_grants, run[0], run[1], LIMIT);
            end
        end else begin
            if (if_grants != 0 || mem_grants < 25) begin
                errors++;
                $display("FAIL strict_priority: got if_grants=%0d mem_grants=%0d expected 0 and >=25",
                         if_grants, mem_grants);
            end
        end
        if_req = 1'b0; mem_req = 1'b0;
        tick; tick; tick;
    endtask

    task automatic test_random;
        bit          if_prev, mem_prev, exp_if_v = 0, exp_mem_v = 0, exp_err = 0, exp_load = 0, exp_men;
        logic [31:0] exp_data = '0;
        int          starve = 0, if_wait = 0, mem_wait = 0;
        for (int cyc = 0; cyc < 3000; cyc++) begin
            if_prev = if_req; mem_prev = mem_req;
            tick;
            checks++;
            if (if_valid !== exp_if_v || mem_valid !== exp_mem_v) begin
                errors++;
                $display("FAIL rnd_valid: got if=%b mem=%b expected if=%b mem=%b at cyc %0d",
                         if_valid, mem_valid, exp_if_v, exp_mem_v, cyc);
            end else if ((exp_if_v || exp_mem_v) && err !== exp_err) begin
                errors++;
                $display("FAIL rnd_err: got %b expected %b at cyc %0d", err, exp_err, cyc);
            end else if (exp_if_v && if_rdata !== exp_data) begin
                errors++;
                $display("FAIL rnd_if_data: got %0h expected %0h at cyc %0d", if_rdata, exp_data, cyc);
            end else if (exp_mem_v && exp_load && mem_rdata !== exp_data) begin
                errors++;
                $display("FAIL rnd_mem_data: got %0h expected %0h at cyc %0d", mem_rdata, exp_data, cyc);
            end
            exp_if_v = 0; exp_mem_v = 0;

            exp_men = 0;
            if (if_gnt === 1'b1)  exp_men = (if_addr < DEPTH);
            if (mem_gnt === 1'b1) exp_men = (mem_addr < DEPTH);
            checks++;
            if (if_gnt === 1'b1 && mem_gnt === 1'b1) begin
                errors++;
                $display("FAIL rnd_dual_gnt: got both grants expected one at cyc %0d", cyc);
            end else if ((if_gnt === 1'b1 && !if_prev) || (mem_gnt === 1'b1 && !mem_prev)) begin
                errors++;
                $display("FAIL rnd_spurious_gnt: got if=%b mem=%b with req if=%b mem=%b at cyc %0d",
                         if_gnt, mem_gnt, if_prev, mem_prev, cyc);
            end else if (if_gnt === 1'b1 && mem_prev && !(FAIR && starve == LIMIT)) begin
                errors++;
                $display("FAIL rnd_priority: got IF grant expected MEM grant (starve=%0d) at cyc %0d", starve, cyc);
            end else if (mem_gnt === 1'b1 && if_prev && FAIR && starve == LIMIT) begin
                errors++;
                $display("FAIL rnd_fairness: got MEM grant expected IF grant at cyc %0d", cyc);
            end else if (m_en !== exp_men) begin
                errors++;
                $display("FAIL rnd_m_en: got %b expected %b at cyc %0d", m_en, exp_men, cyc);
            end else if (if_wait > 40 || mem_wait > 40) begin
                errors++;
                $display("FAIL rnd_timeout: got waits if=%0d mem=%0d expected <=40", if_wait, mem_wait);
                if_wait = 0; mem_wait = 0;
            end

            if (if_gnt === 1'b1) begin
                exp_if_v = 1; exp_err = (if_addr >= DEPTH);
                exp_data = exp_err ? 32'd0 : ref_mem[if_addr[10:0]];
                starve = 0; if_req = 1'b0; if_wait = 0;
            end
            if (mem_gnt === 1'b1) begin
                exp_mem_v = 1; exp_err = (mem_addr >= DEPTH); exp_load = !mem_we;
                exp_data = '0;
                if (!exp_err) begin
                    if (mem_we) ref_mem[mem_addr[10:0]] = mem_wdata;
                    else        exp_data = ref_mem[mem_addr[10:0]];
                end
                if (if_prev && starve < LIMIT) starve++;
                mem_req = 1'b0; mem_wait = 0;
            end
            if (!if_prev) starve = 0;

            if (if_req)  if_wait++;
            if (mem_req) mem_wait++;
            if (!if_req && $urandom_range(0, 1) == 1) begin
                if_req = 1'b1; if_addr = pick_addr();
            end
            if (!mem_req && $urandom_range(0, 1) == 1) begin
                mem_req = 1'b1; mem_we = 1'($urandom_range(0, 1));
                mem_addr = pick_addr(); mem_wdata = $urandom;
            end
        end
        if_req = 1'b0; mem_req = 1'b0;
        tick; tick; tick;
    endtask

    initial begin
        test_reset;
        test_if_read;
        test_store_load;
        test_both;
        test_out_of_range;
        test_reset_mid;
        test_priority;
        test_random;
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
